// File: rtl/mvm_pkg.sv
// Shared state encoding and size helpers for the MVM stream controller.
package mvm_pkg;

  typedef enum logic [1:0] {
    StFill   = 2'd0,
    StLaunch = 2'd1,
    StWait   = 2'd2,
    StDrain  = 2'd3
  } mvm_state_e;

  function automatic int unsigned mat_beats(input int unsigned n);
    return n * n;
  endfunction

  function automatic int unsigned n_in(input int unsigned n);
    return n * n + n;
  endfunction

endpackage

// File: rtl/mvm_result_serializer.sv
// Holds the captured result vector and streams it out one element per handshake.
module mvm_result_serializer #(
  parameter int unsigned N     = 3,
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 capture_i,
  input  logic [N*WIDTH-1:0]   vec_c_i,
  input  logic                 active_i,
  input  logic                 m_ready_i,
  output logic                 m_valid_o,
  output logic [WIDTH-1:0]     m_data_o,
  output logic                 m_last_o,
  output logic                 done_o
);

  localparam int unsigned OutW = (N > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] res_q, res_d;
  logic [OutW-1:0]    out_idx_q, out_idx_d;
  logic               fire;
  logic               at_last;

  assign at_last   = (out_idx_q == OutW'(N - 1));
  assign fire      = active_i && m_ready_i && !clr_i;
  assign m_valid_o = active_i;
  assign m_last_o  = active_i && at_last;
  assign done_o    = fire && at_last;

  always_comb begin
    m_data_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (out_idx_q == OutW'(k)) m_data_o = res_q[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    res_d     = res_q;
    out_idx_d = out_idx_q;
    if (capture_i) res_d = vec_c_i;
    if (clr_i) begin
      out_idx_d = '0;
    end else if (fire) begin
      out_idx_d = at_last ? '0 : out_idx_q + OutW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      out_idx_q <= '0;
    end else begin
      res_q     <= res_d;
      out_idx_q <= out_idx_d;
    end
  end

endmodule

// File: rtl/mvm_stream_controller.sv
// Streams operands into the NxN MVM accelerator, launches it, and streams the result back.
module mvm_stream_controller
  import mvm_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [WIDTH-1:0]       s_data_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [WIDTH-1:0]       m_data_o,
  output logic                   m_last_o,
  output logic                   mvm_ena_o,
  output logic [N*N*WIDTH-1:0]   mvm_matrix_a_o,
  output logic [N*WIDTH-1:0]     mvm_vector_b_o,
  input  logic [N*WIDTH-1:0]     mvm_vector_c_i,
  input  logic                   mvm_done_i,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int unsigned NIn      = n_in(N);
  localparam int unsigned MatBeats = mat_beats(N);
  localparam int unsigned InW      = $clog2(NIn);
  localparam int unsigned TmoW     = $clog2(TIMEOUT + 1);

  mvm_state_e           state_q, state_d;
  logic [InW-1:0]       in_idx_q, in_idx_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic                 ena_q, ena_d;
  logic [N*N*WIDTH-1:0] mat_q, mat_d;
  logic [N*WIDTH-1:0]   vec_q, vec_d;
  logic                 s_fire;
  logic                 capture;
  logic                 drain_done;

  assign s_ready_o      = (state_q == StFill);
  assign s_fire         = s_valid_i && s_ready_o && !clr_i;
  assign mvm_ena_o      = ena_q;
  assign err_o          = err_q;
  assign mvm_matrix_a_o = mat_q;
  assign mvm_vector_b_o = vec_q;
  assign busy_o         = !((state_q == StFill) && (in_idx_q == '0));

  // Operand slots only change in FILL, so they stay frozen while the accelerator runs.
  always_comb begin
    mat_d = mat_q;
    vec_d = vec_q;
    if (s_fire) begin
      for (int unsigned j = 0; j < MatBeats; j++) begin
        if (in_idx_q == InW'(j)) mat_d[j*WIDTH +: WIDTH] = s_data_i;
      end
      for (int unsigned k = 0; k < N; k++) begin
        if (in_idx_q == InW'(MatBeats + k)) vec_d[k*WIDTH +: WIDTH] = s_data_i;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    in_idx_d = in_idx_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    ena_d    = 1'b0;
    capture  = 1'b0;
    if (clr_i) begin
      state_d  = StFill;
      in_idx_d = '0;
      tmo_d    = '0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (s_fire) begin
            if (in_idx_q == InW'(NIn - 1)) begin
              in_idx_d = '0;
              state_d  = StLaunch;
              ena_d    = 1'b1;
            end else begin
              in_idx_d = in_idx_q + InW'(1);
            end
          end
        end
        StLaunch: state_d = StWait;
        StWait: begin
          if (mvm_done_i) begin
            capture = 1'b1;
            tmo_d   = '0;
            state_d = StDrain;
          end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            tmo_d   = '0;
            state_d = StFill;
          end else begin
            tmo_d = tmo_q + TmoW'(1);
          end
        end
        StDrain: begin
          if (drain_done) state_d = StFill;
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFill;
      in_idx_q <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      ena_q    <= 1'b0;
      mat_q    <= '0;
      vec_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_idx_q <= in_idx_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      ena_q    <= ena_d;
      mat_q    <= mat_d;
      vec_q    <= vec_d;
    end
  end

  mvm_result_serializer #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr_i),
    .capture_i (capture),
    .vec_c_i   (mvm_vector_c_i),
    .active_i  (state_q == StDrain),
    .m_ready_i (m_ready_i),
    .m_valid_o (m_valid_o),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o),
    .done_o    (drain_done)
  );

endmodule
